// File: rtl/mul_iter_pkg.sv
// Shared ALU definitions for the iterative multiplier.
// Holds the 2-bit multiply control encodings, the matching divide encodings
// used by the combinational divide unit, the multiplier state encoding, and
// a helper that returns the magnitude of an operand that may be read as signed.
package mul_iter_pkg;

    // Multiply control encodings (RV64M MUL group)
    localparam logic [1:0] MUL_LO = 2'b00;  // low half, sign-agnostic
    localparam logic [1:0] MULH   = 2'b01;  // signed x signed, high half
    localparam logic [1:0] MULHSU = 2'b10;  // signed x unsigned, high half
    localparam logic [1:0] MULHU  = 2'b11;  // unsigned x unsigned, high half

    // Divide control encodings (combinational divide unit)
    localparam logic [1:0] DIV_S  = 2'b00;
    localparam logic [1:0] DIV_U  = 2'b01;
    localparam logic [1:0] REM_S  = 2'b10;
    localparam logic [1:0] REM_U  = 2'b11;

    // Multiplier state encoding
    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_CALC_ENC  = 2'd1;
    localparam logic [1:0] ST_FIXUP_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_CALC  = ST_CALC_ENC,
        ST_FIXUP = ST_FIXUP_ENC,
        ST_DONE  = ST_DONE_ENC
    } mul_state_t;

    // Magnitude of a 64-bit operand. The most-negative value maps to 2^63,
    // which is still representable as an unsigned 64-bit quantity.
    function automatic logic [63:0] mag64(input logic [63:0] val, input logic is_neg);
        return is_neg ? (~val + 64'd1) : val;
    endfunction

endpackage

// File: rtl/mul_iter_step.sv
// One shift-add step of the iterative multiplier.
// Adds mcand_i x digit_i into the accumulator. mcand_i is already shifted
// into place by the caller, so this block is purely combinational.
// Ports:
//   acc_i    accumulator before the step
//   mcand_i  multiplicand aligned to the current digit position
//   digit_i  STEP_BITS-wide slice of the multiplier
//   acc_o    accumulator after the step
module mul_iter_step #(
    parameter int AW        = 128,
    parameter int STEP_BITS = 2
) (
    input  logic [AW-1:0]        acc_i,
    input  logic [AW-1:0]        mcand_i,
    input  logic [STEP_BITS-1:0] digit_i,
    output logic [AW-1:0]        acc_o
);

    logic [AW-1:0] pp;

    always_comb begin
        pp = '0;
        for (int j = 0; j < STEP_BITS; j++) begin
            if (digit_i[j]) begin
                pp = pp + (mcand_i << j);
            end
        end
        acc_o = acc_i + pp;
    end

endmodule

// File: rtl/mul_iter.sv
// Iterative shift-add integer multiplier (MUL/MULH/MULHSU/MULHU).
// Operands are reduced to magnitudes on acceptance, multiplied STEP_BITS
// multiplier bits per cycle, then sign-corrected once at the end.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (ready only in IDLE)
//   in1, in2, control   multiplicand, multiplier, 2-bit op select
//   flush               abort and return to IDLE
//   out_valid/out_ready result handshake
//   out                 selected result half
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | one shift-add step per cycle, counter counts down to 1
// FIXUP | negate accumulator if needed, register result half
// DONE  | result held with out_valid high until out_ready
module mul_iter
    import mul_iter_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int STEP_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       control,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);

    localparam int NSTEPS = WIDTH / STEP_BITS;
    localparam int CW     = $clog2(NSTEPS + 1);
    localparam int AW     = 2 * WIDTH;

    if (!((STEP_BITS == 1) || (STEP_BITS == 2) || (STEP_BITS == 4)) ||
        ((WIDTH % STEP_BITS) != 0) || (WIDTH != 64)) begin : g_bad_param
        $error("mul_iter: unsupported WIDTH/STEP_BITS combination");
    end

    mul_state_t state_q, state_d;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [AW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [1:0]       ctl_q, ctl_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] out_q, out_d;

    logic             accept;
    logic             sgn1, sgn2;
    logic [AW-1:0]    acc_step;
    logic [AW-1:0]    acc_fix;

    // flush blocks acceptance even though in_ready is still high in IDLE
    assign accept = in_valid && (state_q == ST_IDLE) && !flush;

    assign sgn1 = ((control == MULH) || (control == MULHSU)) && in1[WIDTH-1];
    assign sgn2 = (control == MULH) && in2[WIDTH-1];

    mul_iter_step #(
        .AW        (AW),
        .STEP_BITS (STEP_BITS)
    ) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .digit_i (mplier_q[STEP_BITS-1:0]),
        .acc_o   (acc_step)
    );

    assign acc_fix = neg_q ? (~acc_q + {{(AW-1){1'b0}}, 1'b1}) : acc_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (accept) state_d = ST_CALC;
                ST_CALC:  if (cnt_q == CW'(1)) state_d = ST_FIXUP;
                ST_FIXUP: state_d = ST_DONE;
                ST_DONE:  if (out_ready) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        out       = out_q;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            ctl_q    <= MUL_LO;
            neg_q    <= 1'b0;
            out_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            ctl_q    <= ctl_d;
            neg_q    <= neg_d;
            out_q    <= out_d;
        end
    end

    // Datapath next-state
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        ctl_d    = ctl_q;
        neg_d    = neg_q;
        out_d    = out_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ctl_d    = control;
                    mcand_d  = {{WIDTH{1'b0}}, mag64(in1, sgn1)};
                    mplier_d = mag64(in2, sgn2);
                    neg_d    = sgn1 ^ sgn2;
                    acc_d    = '0;
                    cnt_d    = CW'(NSTEPS);
                end
            end
            ST_CALC: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << STEP_BITS;
                mplier_d = mplier_q >> STEP_BITS;
                cnt_d    = cnt_q - CW'(1);
            end
            ST_FIXUP: begin
                if (!flush) begin
                    acc_d = acc_fix;
                    out_d = (ctl_q == MUL_LO) ? acc_fix[WIDTH-1:0] : acc_fix[AW-1:WIDTH];
                end
            end
            default: ;
        endcase
    end

endmodule
